// File: rtl/reconfig_multi_topology_a.sv
// Two-stage shared-adder datapath: {s1,s0} picks the operand pair, the sum is registered into y.
// Optional clamp to 2^WIDTH-1 when RECONFIG_MULTI_TOPOLOGY_A_SAT_EN is defined.
module reconfig_multi_topology_a #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] a1,
    input  logic [WIDTH-1:0] a2,
    input  logic [WIDTH-1:0] a3,
    input  logic [WIDTH-1:0] b,
    input  logic             s0,
    input  logic             s1,
    output logic [WIDTH:0]   y,
    output logic             out_valid
);

    logic [WIDTH-1:0] a1_q, a1_d;
    logic [WIDTH-1:0] a2_q, a2_d;
    logic [WIDTH-1:0] a3_q, a3_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [1:0]       sel_q, sel_d;
    logic             valid1_q, valid1_d;
    logic [WIDTH:0]   y_q, y_d;
    logic             out_valid_q, out_valid_d;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   result;

    // Stage 1 captures operands and select together so they are never mixed across cycles.
    always_comb begin
        a1_d     = a1_q;
        a2_d     = a2_q;
        a3_d     = a3_q;
        b_d      = b_q;
        sel_d    = sel_q;
        valid1_d = in_valid;
        if (in_valid) begin
            a1_d  = a1;
            a2_d  = a2;
            a3_d  = a3;
            b_d   = b;
            sel_d = {s1, s0};
        end
    end

    always_comb begin
        op_a = a1_q;
        op_b = b_q;
        case (sel_q)
            2'b00: begin op_a = a1_q; op_b = b_q;  end
            2'b01: begin op_a = a2_q; op_b = b_q;  end
            2'b10: begin op_a = a3_q; op_b = b_q;  end
            2'b11: begin op_a = a1_q; op_b = a2_q; end
            default: begin op_a = a1_q; op_b = b_q; end
        endcase
        sum = {1'b0, op_a} + {1'b0, op_b};
`ifdef RECONFIG_MULTI_TOPOLOGY_A_SAT_EN
        result = sum[WIDTH] ? {1'b0, {WIDTH{1'b1}}} : sum;
`else
        result = sum;
`endif
        // y only moves when stage 1 held a fresh sample; otherwise it keeps the last result.
        y_d         = valid1_q ? result : y_q;
        out_valid_d = valid1_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a1_q        <= '0;
            a2_q        <= '0;
            a3_q        <= '0;
            b_q         <= '0;
            sel_q       <= '0;
            valid1_q    <= 1'b0;
            y_q         <= '0;
            out_valid_q <= 1'b0;
        end else begin
            a1_q        <= a1_d;
            a2_q        <= a2_d;
            a3_q        <= a3_d;
            b_q         <= b_d;
            sel_q       <= sel_d;
            valid1_q    <= valid1_d;
            y_q         <= y_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign y         = y_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_reconfig_multi_topology_a.sv
// Scoreboard bench for reconfig_multi_topology_a: each accepted input pushes its expected sum
// and due cycle; a monitor checks out_valid/y every cycle, including hold and reset behaviour.
module tb_reconfig_multi_topology_a;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic [W-1:0] a1, a2, a3, b;
    logic         s0, s1;
    logic [W:0]   y;
    logic         out_valid;

    typedef struct {
        int         due;
        logic [W:0] y;
    } exp_t;

    exp_t       sb_q[$];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;
    logic [W:0] last_y = '0;

    reconfig_multi_topology_a #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a1        (a1),
        .a2        (a2),
        .a3        (a3),
        .b         (b),
        .s0        (s0),
        .s1        (s1),
        .y         (y),
        .out_valid (out_valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference sum computed in integer arithmetic, independent of the RTL datapath.
    function automatic logic [W:0] model(input logic [1:0] sel, input logic [W-1:0] i1,
                                         input logic [W-1:0] i2, input logic [W-1:0] i3,
                                         input logic [W-1:0] ib);
        int s;
        case (sel)
            2'd0:    s = int'(i1) + int'(ib);
            2'd1:    s = int'(i2) + int'(ib);
            2'd2:    s = int'(i3) + int'(ib);
            default: s = int'(i1) + int'(i2);
        endcase
`ifdef RECONFIG_MULTI_TOPOLOGY_A_SAT_EN
        if (s > 255) s = 255;
`endif
        return s[W:0];
    endfunction

    task automatic checkOutput(input string tag, input logic [W:0] obs, input logic [W:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Drive one cycle of inputs at the falling edge; accepted inputs are due two edges later.
    task automatic applyStimulus(input logic v, input logic [1:0] sel, input logic [W-1:0] i1,
                                 input logic [W-1:0] i2, input logic [W-1:0] i3,
                                 input logic [W-1:0] ib);
        exp_t e;
        @(negedge clk);
        in_valid = v;
        s1 = sel[1];
        s0 = sel[0];
        a1 = i1;
        a2 = i2;
        a3 = i3;
        b  = ib;
        if (v) begin
            e.due = cyc + 2;
            e.y   = model(sel, i1, i2, i3, ib);
            sb_q.push_back(e);
        end
    endtask

    // Monitor: every cycle either a result is due (valid + value) or y must hold quietly.
    always @(posedge clk) begin
        cyc++;
        #1;
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            checkOutput("out_valid", {8'd0, out_valid}, 9'd1);
            checkOutput("y_result", y, sb_q[0].y);
            last_y = sb_q[0].y;
            void'(sb_q.pop_front());
        end else begin
            checkOutput("out_valid_idle", {8'd0, out_valid}, 9'd0);
            checkOutput("y_hold", y, last_y);
        end
    end

    initial begin
        logic [W:0] sat_303;
        logic [W:0] sat_318;
`ifdef RECONFIG_MULTI_TOPOLOGY_A_SAT_EN
        sat_303 = 9'd255;
        sat_318 = 9'd255;
`else
        sat_303 = 9'd303;
        sat_318 = 9'd318;
`endif
        in_valid = 1'b0;
        {s1, s0} = 2'b00;
        a1 = '0; a2 = '0; a3 = '0; b = '0;
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        #1;
        checkOutput("reset_y", y, 9'd0);
        checkOutput("reset_out_valid", {8'd0, out_valid}, 9'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        $display("[TB] reset released at cycle %0d", cyc);

        // Individual selects with the reference operands.
        if (model(2'b00, 8'd240, 8'd1, 8'd255, 8'd63) !== sat_303)
            $display("[TB] note: model/constant disagreement for select 00");
        applyStimulus(1'b1, 2'b00, 8'd240, 8'd1, 8'd255, 8'd63);
        applyStimulus(1'b0, 2'b00, 8'd240, 8'd1, 8'd255, 8'd63);
        applyStimulus(1'b0, 2'b00, 8'd240, 8'd1, 8'd255, 8'd63);
        checkOutput("case1_y", y, sat_303);
        applyStimulus(1'b1, 2'b01, 8'd240, 8'd1, 8'd255, 8'd63);
        applyStimulus(1'b0, 2'b01, 8'd240, 8'd1, 8'd255, 8'd63);
        applyStimulus(1'b0, 2'b01, 8'd240, 8'd1, 8'd255, 8'd63);
        checkOutput("case2_y", y, 9'd64);
        applyStimulus(1'b1, 2'b10, 8'd240, 8'd1, 8'd255, 8'd63);
        applyStimulus(1'b0, 2'b10, 8'd240, 8'd1, 8'd255, 8'd63);
        applyStimulus(1'b0, 2'b10, 8'd240, 8'd1, 8'd255, 8'd63);
        checkOutput("case3_y", y, sat_318);
        applyStimulus(1'b1, 2'b11, 8'd240, 8'd1, 8'd255, 8'd63);
        applyStimulus(1'b1, 2'b11, 8'd240, 8'd1, 8'd255, 8'd0);
        applyStimulus(1'b0, 2'b11, 8'd240, 8'd1, 8'd255, 8'd0);
        applyStimulus(1'b0, 2'b11, 8'd240, 8'd1, 8'd255, 8'd0);
        checkOutput("case4_b_ignored", y, 9'd241);

        // Back-to-back selects, then idle with changed inputs: y must hold 241.
        applyStimulus(1'b1, 2'b00, 8'd240, 8'd1, 8'd255, 8'd63);
        applyStimulus(1'b1, 2'b01, 8'd240, 8'd1, 8'd255, 8'd63);
        applyStimulus(1'b1, 2'b10, 8'd240, 8'd1, 8'd255, 8'd63);
        applyStimulus(1'b1, 2'b11, 8'd240, 8'd1, 8'd255, 8'd63);
        applyStimulus(1'b0, 2'b00, 8'd7, 8'd9, 8'd11, 8'd13);
        applyStimulus(1'b0, 2'b10, 8'd7, 8'd9, 8'd11, 8'd13);
        applyStimulus(1'b0, 2'b01, 8'd7, 8'd9, 8'd11, 8'd13);
        checkOutput("case5_hold", y, 9'd241);

        // Asynchronous reset with results in flight.
        applyStimulus(1'b1, 2'b00, 8'd100, 8'd50, 8'd25, 8'd5);
        applyStimulus(1'b1, 2'b01, 8'd100, 8'd50, 8'd25, 8'd5);
        applyStimulus(1'b1, 2'b10, 8'd100, 8'd50, 8'd25, 8'd5);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        in_valid = 1'b0;
        sb_q.delete();
        last_y = '0;
        #1;
        checkOutput("async_reset_y", y, 9'd0);
        checkOutput("async_reset_out_valid", {8'd0, out_valid}, 9'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
        applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
        applyStimulus(1'b1, 2'b11, 8'd200, 8'd100, 8'd1, 8'd1);
        applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
        applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);

        // Random mix of valid and idle cycles, including boundary operand values.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] r1, r2, r3, rb;
            r1 = (i % 7 == 0) ? 8'hFF : 8'($urandom);
            r2 = (i % 5 == 0) ? 8'hFF : 8'($urandom);
            r3 = (i % 6 == 0) ? 8'h00 : 8'($urandom);
            rb = (i % 4 == 0) ? 8'hFF : 8'($urandom);
            applyStimulus($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), r1, r2, r3, rb);
        end
        repeat (4) applyStimulus(1'b0, 2'b00, 8'd0, 8'd0, 8'd0, 8'd0);
        checkOutput("scoreboard_drained", 9'(sb_q.size()), 9'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
